// File: rtl/counter_b4_seq.sv
// Command sequencer for counter_b4: turns LOAD/RUN commands into enable/mode/D pin
// activity and reports each finished command with done, a wrap count and the final Q.
module counter_b4_seq #(
    parameter int LEN_W    = 8,
    parameter int WRAP_W   = 8,
    parameter int LOAD_TMO = 4
) (
    input  logic              sq_clk,
    input  logic              sq_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [3:0]        cmd_data,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              cnt_enable,
    output logic              cnt_reset,
    output logic [1:0]        cnt_mode,
    output logic [3:0]        cnt_D,
    input  logic              cnt_load,
    input  logic              cnt_rco,
    input  logic [3:0]        cnt_Q,
    output logic              done,
    output logic [WRAP_W-1:0] wraps,
    output logic [3:0]        q_final,
    output logic              timeout_err
);

    localparam int TMO_W = $clog2(LOAD_TMO + 1);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_LOAD  = 3'd2,
        S_LWAIT = 3'd3,
        S_RUN   = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t state_reg, state_next;

    logic [LEN_W-1:0]  run_cnt_reg, run_cnt_next;
    logic [WRAP_W-1:0] wrap_cnt_reg, wrap_cnt_next, wrap_inc;
    logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;

    logic              cnt_enable_next, cnt_reset_next, cmd_ready_next;
    logic [1:0]        cnt_mode_next;
    logic [3:0]        cnt_D_next;
    logic              done_next, timeout_err_next;
    logic [WRAP_W-1:0] wraps_next;
    logic [3:0]        q_final_next;

    logic accept, is_load, tmo_expired, counting;

    assign accept      = (state_reg == S_IDLE) && cmd_valid && cmd_ready;
    assign is_load     = (cmd_mode == 2'b11);
    assign tmo_expired = (tmo_cnt_reg == TMO_W'(LOAD_TMO - 1));
    assign counting    = (state_reg == S_RUN) || (state_reg == S_DRAIN);

    // Saturating wrap tally including the rco seen this cycle, so the value
    // copied on the DRAIN exit edge already contains the final pulse.
    always_comb begin
        wrap_inc = wrap_cnt_reg;
        if (counting && cnt_rco && (wrap_cnt_reg != {WRAP_W{1'b1}})) begin
            wrap_inc = wrap_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge sq_clk or negedge sq_reset) begin
        if (!sq_reset) begin
            state_reg <= S_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_INIT:  state_next = S_IDLE;
            S_IDLE: begin
                if (accept) begin
                    if (is_load) begin
                        state_next = S_LOAD;
                    end else if (cmd_len != '0) begin
                        state_next = S_RUN;
                    end else begin
                        // Zero-length run still passes through DRAIN for a 1-cycle done latency
                        state_next = S_DRAIN;
                    end
                end
            end
            S_LOAD:  state_next = S_LWAIT;
            S_LWAIT: begin
                if (cnt_load || tmo_expired) begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (run_cnt_reg == LEN_W'(1)) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: state_next = S_IDLE;
            default: state_next = S_INIT;
        endcase
    end

    always_comb begin
        cnt_enable_next  = (state_next == S_LOAD) || (state_next == S_RUN);
        cnt_reset_next   = (state_next == S_INIT);
        cmd_ready_next   = (state_next == S_IDLE);
        cnt_mode_next    = cnt_mode;
        cnt_D_next       = cnt_D;
        done_next        = 1'b0;
        timeout_err_next = timeout_err;
        wraps_next       = wraps;
        q_final_next     = q_final;
        run_cnt_next     = run_cnt_reg;
        wrap_cnt_next    = wrap_cnt_reg;
        tmo_cnt_next     = tmo_cnt_reg;

        if (accept) begin
            timeout_err_next = 1'b0;
            wrap_cnt_next    = '0;
            run_cnt_next     = cmd_len;
            if (is_load) begin
                cnt_mode_next = 2'b11;
                cnt_D_next    = cmd_data;
            end else begin
                cnt_mode_next = cmd_mode;
            end
        end

        case (state_reg)
            S_LOAD: tmo_cnt_next = '0;
            S_LWAIT: begin
                if (cnt_load) begin
                    done_next    = 1'b1;
                    q_final_next = cnt_Q;
                    wraps_next   = '0;
                end else if (tmo_expired) begin
                    done_next        = 1'b1;
                    timeout_err_next = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            S_RUN: begin
                run_cnt_next  = run_cnt_reg - 1'b1;
                wrap_cnt_next = wrap_inc;
            end
            S_DRAIN: begin
                wrap_cnt_next = wrap_inc;
                done_next     = 1'b1;
                q_final_next  = cnt_Q;
                wraps_next    = wrap_inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sq_clk or negedge sq_reset) begin
        if (!sq_reset) begin
            cnt_enable   <= 1'b0;
            cnt_reset    <= 1'b1;
            cmd_ready    <= 1'b0;
            cnt_mode     <= 2'b00;
            cnt_D        <= 4'h0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            wraps        <= '0;
            q_final      <= 4'h0;
            run_cnt_reg  <= '0;
            wrap_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
        end else begin
            cnt_enable   <= cnt_enable_next;
            cnt_reset    <= cnt_reset_next;
            cmd_ready    <= cmd_ready_next;
            cnt_mode     <= cnt_mode_next;
            cnt_D        <= cnt_D_next;
            done         <= done_next;
            timeout_err  <= timeout_err_next;
            wraps        <= wraps_next;
            q_final      <= q_final_next;
            run_cnt_reg  <= run_cnt_next;
            wrap_cnt_reg <= wrap_cnt_next;
            tmo_cnt_reg  <= tmo_cnt_next;
        end
    end

endmodule
